// File: rtl/sisc_wb_pkg.sv
// Shared write-back types: command codes, mux-select constants, sequencer state encodings.
// No logic, so no latency.
// No backpressure; types only.
package sisc_wb_pkg;

    // Write-back command carried on wb_type
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_SWAP = 2'd3
    } wb_type_e;

    // Select codes for the 32-bit 4:1 write-back data mux
    localparam logic [1:0] SEL_ALU    = 2'd0;
    localparam logic [1:0] SEL_MEM    = 2'd1;
    localparam logic [1:0] SEL_SWAP_A = 2'd2;
    localparam logic [1:0] SEL_SWAP_B = 2'd3;

    // Sequencer states; SW1 writes swap_b to rd_a, SW2 writes swap_a to rd_b
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_SW1  = 2'd2,
        ST_SW2  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_seq_ctrl_if.sv
// Bundle between control unit, write-back sequencer and register-file write port.
// Wires only, no latency.
// wb_req/wb_ready is a valid-ready handshake; the register-file side has no backpressure.
interface wb_seq_ctrl_if
    import sisc_wb_pkg::*;
#(
    parameter int AW = 4
);
    logic          wb_req;
    logic          wb_ready;
    wb_type_e      wb_type;
    logic [AW-1:0] rd_a;
    logic [AW-1:0] rd_b;
    logic [1:0]    mux_sel;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic          swap_hold;
    logic          wb_done;

    // Control-unit side: issues commands, observes the write-back outputs
    modport master (
        output wb_req, wb_type, rd_a, rd_b,
        input  wb_ready, mux_sel, rf_we, rf_waddr, swap_hold, wb_done
    );

    // Sequencer side
    modport slave (
        input  wb_req, wb_type, rd_a, rd_b,
        output wb_ready, mux_sel, rf_we, rf_waddr, swap_hold, wb_done
    );
endinterface

// File: rtl/wb_seq_ctrl.sv
// Write-back sequencer: turns ALU/MEM/NONE/SWAP commands into register-file writes and mux selects.
// Latency 1 cycle (command accepted at edge k drives outputs in cycle k+1); SWAP occupies 2 cycles.
// wb_ready drops only in SW1, giving 1 single write per cycle and 1 SWAP per 2 cycles.
module wb_seq_ctrl
    import sisc_wb_pkg::*;
#(
    parameter int AW         = 4,
    parameter bit R0_PROTECT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    wb_seq_ctrl_if.slave bus
);

    wb_state_e     state;
    wb_state_e     state_nxt;
    logic          accept;
    logic [AW-1:0] rd_b_q;
    logic [1:0]    mux_sel_q;
    logic          rf_we_q;
    logic [AW-1:0] rf_waddr_q;
    logic          swap_hold_q;
    logic          wb_done_q;

    // A write to R0 is dropped when protection is on; everything else proceeds as usual
    function automatic logic wr_allowed(input logic [AW-1:0] addr);
        return !(R0_PROTECT && (addr == '0));
    endfunction

    // Ready whenever the next cycle is free; SW1 always continues into SW2
    assign bus.wb_ready = !rst && (state != ST_SW1);
    assign accept       = bus.wb_req && bus.wb_ready;

    // Next-state selection
    always_comb begin
        state_nxt = ST_IDLE;
        if (state == ST_SW1) begin
            state_nxt = ST_SW2;
        end else if (accept) begin
            state_nxt = (bus.wb_type == WB_SWAP) ? ST_SW1 : ST_WB;
        end
    end

    // State register plus registered outputs describing the cycle being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_b_q      <= '0;
            mux_sel_q   <= SEL_ALU;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            swap_hold_q <= 1'b0;
            wb_done_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_SW1) begin
                // Second half of SWAP: swap_a goes to the latched rd_b
                mux_sel_q   <= SEL_SWAP_A;
                rf_waddr_q  <= rd_b_q;
                rf_we_q     <= wr_allowed(rd_b_q);
                swap_hold_q <= 1'b1;
                wb_done_q   <= 1'b1;
            end else if (accept && (bus.wb_type == WB_SWAP)) begin
                // First half of SWAP: swap_b goes to rd_a
                rd_b_q      <= bus.rd_b;
                mux_sel_q   <= SEL_SWAP_B;
                rf_waddr_q  <= bus.rd_a;
                rf_we_q     <= wr_allowed(bus.rd_a);
                swap_hold_q <= 1'b1;
                wb_done_q   <= 1'b0;
            end else if (accept) begin
                mux_sel_q   <= (bus.wb_type == WB_MEM) ? SEL_MEM : SEL_ALU;
                rf_waddr_q  <= bus.rd_a;
                rf_we_q     <= (bus.wb_type != WB_NONE) && wr_allowed(bus.rd_a);
                swap_hold_q <= 1'b0;
                wb_done_q   <= 1'b1;
            end else begin
                // Idle: mux_sel and rf_waddr keep their last value
                rf_we_q     <= 1'b0;
                swap_hold_q <= 1'b0;
                wb_done_q   <= 1'b0;
            end
        end
    end

    assign bus.mux_sel   = mux_sel_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.swap_hold = swap_hold_q;
    assign bus.wb_done   = wb_done_q;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Bench for wb_seq_ctrl: directed commands push expected write-back cycles into a scoreboard,
// an independent monitor pops and compares whenever the sequencer shows activity.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_wb_seq_ctrl;
    import sisc_wb_pkg::*;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic       sel_dc;
        logic [3:0] addr;
        logic       we;
        logic       hold;
        logic       done;
        string      nm;
    } exp_t;

    exp_t sbq[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   we_cnt = 0;
    int   done_cnt = 0;

    wb_seq_ctrl_if #(.AW(4)) bus ();

    wb_seq_ctrl #(.AW(4), .R0_PROTECT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: value N is seen between rising edge N and N+1
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference rule: with R0 protection any write to address 0 is suppressed
    function automatic logic we_of(input logic [3:0] a);
        return a != 4'd0;
    endfunction

    function automatic void push(input int c, input logic [1:0] sel, input logic dc,
                                 input logic [3:0] addr, input logic we, input logic hold,
                                 input logic done, input string nm);
        exp_t e;
        e.cyc = c; e.sel = sel; e.sel_dc = dc; e.addr = addr;
        e.we = we; e.hold = hold; e.done = done; e.nm = nm;
        sbq.push_back(e);
    endfunction

    // Present a command and hold it until accepted; returns 1 unit after the accepting edge
    task automatic issue(input wb_type_e t, input logic [3:0] a, input logic [3:0] b,
                         input string nm, input bit no_sw2 = 1'b0);
        bit ok = 1'b0;
        bus.wb_req  = 1'b1;
        bus.wb_type = t;
        bus.rd_a    = a;
        bus.rd_b    = b;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (bus.wb_ready === 1'b1) begin
                ok = 1'b1;
                case (t)
                    WB_ALU:  push(cyc + 1, 2'd0, 1'b0, a, we_of(a), 1'b0, 1'b1, nm);
                    WB_MEM:  push(cyc + 1, 2'd1, 1'b0, a, we_of(a), 1'b0, 1'b1, nm);
                    WB_NONE: push(cyc + 1, 2'd0, 1'b1, a, 1'b0, 1'b0, 1'b1, nm);
                    default: begin
                        push(cyc + 1, 2'd3, 1'b0, a, we_of(a), 1'b1, 1'b0, {nm, ".sw1"});
                        if (!no_sw2)
                            push(cyc + 2, 2'd2, 1'b0, b, we_of(b), 1'b1, 1'b1, {nm, ".sw2"});
                    end
                endcase
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s accept: wb_ready stayed low for 8 cycles, expected 1", nm);
        end
    endtask

    task automatic idle(input int n);
        bus.wb_req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every active cycle must match the head of the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rf_we === 1'b1 || bus.wb_done === 1'b1 || bus.swap_hold === 1'b1) begin
                if (bus.rf_we === 1'b1) we_cnt++;
                if (bus.wb_done === 1'b1) done_cnt++;
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected output at cycle %0d: sel=%0d addr=%0d we=%0b hold=%0b done=%0b, expected no activity",
                             cyc, bus.mux_sel, bus.rf_waddr, bus.rf_we, bus.swap_hold, bus.wb_done);
                end else begin
                    e = sbq.pop_front();
                    chk({e.nm, " cycle"}, 32'(cyc), 32'(e.cyc));
                    if (!e.sel_dc) chk({e.nm, " mux_sel"}, 32'(bus.mux_sel), 32'(e.sel));
                    chk({e.nm, " rf_waddr"}, 32'(bus.rf_waddr), 32'(e.addr));
                    chk({e.nm, " rf_we"}, 32'(bus.rf_we), 32'(e.we));
                    chk({e.nm, " swap_hold"}, 32'(bus.swap_hold), 32'(e.hold));
                    chk({e.nm, " wb_done"}, 32'(bus.wb_done), 32'(e.done));
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %s missing: no activity at cycle %0d, expected output due at cycle %0d",
                         e.nm, cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int we0, d0;
        bus.wb_req  = 1'b0;
        bus.wb_type = WB_NONE;
        bus.rd_a    = 4'd0;
        bus.rd_b    = 4'd0;

        // Reset held 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst rf_we",     32'(bus.rf_we),     32'd0);
        chk("rst mux_sel",   32'(bus.mux_sel),   32'd0);
        chk("rst rf_waddr",  32'(bus.rf_waddr),  32'd0);
        chk("rst wb_done",   32'(bus.wb_done),   32'd0);
        chk("rst swap_hold", 32'(bus.swap_hold), 32'd0);
        chk("rst wb_ready",  32'(bus.wb_ready),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst wb_ready", 32'(bus.wb_ready), 32'd1);
        @(posedge clk); #1;

        // Single commands
        issue(WB_ALU, 4'd5, 4'd0, "alu_r5");
        idle(2);
        issue(WB_MEM, 4'd7, 4'd0, "mem_r7");
        idle(2);

        // SWAP with ready checks in SW1 and SW2
        issue(WB_SWAP, 4'd3, 4'd9, "swap_r3_r9");
        chk("swap sw1 wb_ready", 32'(bus.wb_ready), 32'd0);
        idle(1);
        chk("swap sw2 wb_ready", 32'(bus.wb_ready), 32'd1);
        idle(2);

        // Back-to-back stream with wb_req held high
        we0 = we_cnt;
        d0  = done_cnt;
        issue(WB_ALU,  4'd1, 4'd0, "b2b_alu_r1");
        issue(WB_MEM,  4'd2, 4'd0, "b2b_mem_r2");
        issue(WB_SWAP, 4'd4, 4'd6, "b2b_swap_r4_r6");
        issue(WB_ALU,  4'd8, 4'd0, "b2b_alu_r8");
        idle(3);
        chk("b2b write cycles", 32'(we_cnt - we0),  32'd5);
        chk("b2b done pulses",  32'(done_cnt - d0), 32'd4);

        // NONE: completes without a write
        issue(WB_NONE, 4'd11, 4'd0, "none_r11");
        idle(2);

        // R0 protection
        issue(WB_ALU, 4'd0, 4'd0, "alu_r0");
        idle(2);
        issue(WB_SWAP, 4'd0, 4'd2, "swap_r0_r2");
        idle(3);

        // SWAP onto the same register: both writes issued
        issue(WB_SWAP, 4'd5, 4'd5, "swap_r5_r5");
        idle(3);

        // Reset during SW1: the SW2 write to r9 must never appear
        issue(WB_SWAP, 4'd3, 4'd9, "swap_rst", 1'b1);
        bus.wb_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst rf_we",     32'(bus.rf_we),     32'd0);
        chk("midrst mux_sel",   32'(bus.mux_sel),   32'd0);
        chk("midrst rf_waddr",  32'(bus.rf_waddr),  32'd0);
        chk("midrst swap_hold", 32'(bus.swap_hold), 32'd0);
        chk("midrst wb_done",   32'(bus.wb_done),   32'd0);
        chk("midrst wb_ready",  32'(bus.wb_ready),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst release wb_ready", 32'(bus.wb_ready), 32'd1);
        @(posedge clk); #1;
        idle(4);

        chk("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
